// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: RUN, BUBBLE, MEMWAIT, HALTED.
// Drives register enables/flushes, a sticky memory-timeout flag and a stall counter.
//
// Ports:
//   clk, rst (sync, active-low)
//   halt, resume, mem_req, mem_done, branch_taken, load_use : control inputs
//   pc_en, ifid_en, idex_en, exmem_en, memwb_en : register enables
//   ifid_flush, idex_flush : bubble insertion
//   halted, mem_err, stall_cnt[CNT_W-1:0] : status
module pipe_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             resume,
  input  logic             mem_req,
  input  logic             mem_done,
  input  logic             branch_taken,
  input  logic             load_use,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN,
    S_BUBBLE,
    S_MEMWAIT,
    S_HALTED
  } state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);
  localparam logic [4:0] EN_ALL = 5'b11111;
  localparam logic [4:0] EN_LU  = 5'b00111;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_wait;
  logic [7:0]       w_wait_nxt;
  logic             r_err;
  logic             w_err_set;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       w_en;
  logic             w_iff;
  logic             w_idf;
  logic             w_busy;

  assign w_busy = mem_req && !mem_done;

  always_comb begin
    w_next     = r_state;
    w_wait_nxt = r_wait;
    w_err_set  = 1'b0;
    w_en       = 5'b00000;
    w_iff      = 1'b0;
    w_idf      = 1'b0;
    unique case (r_state)
      S_RUN, S_BUBBLE: begin
        if (halt) begin
          w_next = S_HALTED;
        end else if (w_busy) begin
          w_wait_nxt = 8'd1;
          w_next     = S_MEMWAIT;
        end else if (branch_taken) begin
          w_en   = EN_ALL;
          w_iff  = 1'b1;
          w_idf  = 1'b1;
          w_next = S_RUN;
        end else if (load_use && r_state == S_RUN) begin
          // Hold PC and IF/ID, push a bubble into ID/EX.
          w_en   = EN_LU;
          w_idf  = 1'b1;
          w_next = S_BUBBLE;
        end else begin
          w_en   = EN_ALL;
          w_next = S_RUN;
        end
      end
      S_MEMWAIT: begin
        if (mem_done) begin
          w_en       = EN_ALL;
          w_wait_nxt = 8'd0;
          w_next     = S_RUN;
        end else if (r_wait == TO) begin
          w_err_set  = 1'b1;
          w_wait_nxt = 8'd0;
          w_next     = S_HALTED;
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end
      S_HALTED: begin
        if (resume && !halt) begin
          w_next = S_RUN;
        end
      end
      default: w_next = S_RUN;
    endcase
  end

  assign pc_en      = rst && w_en[4];
  assign ifid_en    = rst && w_en[3];
  assign idex_en    = rst && w_en[2];
  assign exmem_en   = rst && w_en[1];
  assign memwb_en   = rst && w_en[0];
  assign ifid_flush = rst && w_iff;
  assign idex_flush = rst && w_idf;
  assign halted     = rst && (r_state == S_HALTED);
  assign mem_err    = r_err;
  assign stall_cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_wait  <= 8'd0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_nxt;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      // Saturating count of cycles where the PC is held.
      if (!w_en[4] && r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus random stimulus against
// a behavioural model; two instances (default params, TIMEOUT=4/CNT_W=4).
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  logic halt;
  logic resume;
  logic mem_req;
  logic mem_done;
  logic branch_taken;
  logic load_use;

  logic        pc16, ifid16, idex16, exmem16, memwb16, iff16, idf16;
  logic        halted16, err16;
  logic [15:0] cnt16;
  logic        pc4, ifid4, idex4, exmem4, memwb4, iff4, idf4;
  logic        halted4, err4;
  logic [3:0]  cnt4;
  logic [6:0]  o16;
  logic [6:0]  o4;

  assign o16 = {pc16, ifid16, idex16, exmem16, memwb16, iff16, idf16};
  assign o4  = {pc4, ifid4, idex4, exmem4, memwb4, iff4, idf4};

  localparam logic [6:0] ALL = 7'b1111100;
  localparam logic [6:0] BR  = 7'b1111111;
  localparam logic [6:0] LU  = 7'b0011101;
  localparam logic [6:0] NONE = 7'b0000000;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl u16 (
    .clk(clk), .rst(rst), .halt(halt), .resume(resume),
    .mem_req(mem_req), .mem_done(mem_done),
    .branch_taken(branch_taken), .load_use(load_use),
    .pc_en(pc16), .ifid_en(ifid16), .idex_en(idex16),
    .exmem_en(exmem16), .memwb_en(memwb16),
    .ifid_flush(iff16), .idex_flush(idf16),
    .halted(halted16), .mem_err(err16), .stall_cnt(cnt16)
  );

  pipe_ctrl #(.TIMEOUT(4), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .halt(halt), .resume(resume),
    .mem_req(mem_req), .mem_done(mem_done),
    .branch_taken(branch_taken), .load_use(load_use),
    .pc_en(pc4), .ifid_en(ifid4), .idex_en(idex4),
    .exmem_en(exmem4), .memwb_en(memwb4),
    .ifid_flush(iff4), .idex_flush(idf4),
    .halted(halted4), .mem_err(err4), .stall_cnt(cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: per instance a halted flag, a bubble flag,
  // a count of cycles spent waiting on memory (0 = not waiting).
  bit m_halt[2];
  bit m_bub[2];
  bit m_err[2];
  int m_wait[2];
  int m_cnt[2];
  int tmo[2]  = '{16, 4};
  int cmax[2] = '{65535, 15};

  function automatic logic [6:0] exp_out(int i);
    if (!rst) return NONE;
    if (m_halt[i]) return NONE;
    if (m_wait[i] > 0) return mem_done ? ALL : NONE;
    if (halt) return NONE;
    if (mem_req && !mem_done) return NONE;
    if (branch_taken) return BR;
    if (load_use && !m_bub[i]) return LU;
    return ALL;
  endfunction

  task automatic upd(int i);
    logic [6:0] o;
    bit bw;
    o = exp_out(i);
    if (!rst) begin
      m_halt[i] = 0;
      m_bub[i]  = 0;
      m_wait[i] = 0;
      m_err[i]  = 0;
      m_cnt[i]  = 0;
      return;
    end
    if (!o[6] && m_cnt[i] < cmax[i]) m_cnt[i]++;
    if (m_halt[i]) begin
      if (resume && !halt) m_halt[i] = 0;
    end else if (m_wait[i] > 0) begin
      if (mem_done) m_wait[i] = 0;
      else if (m_wait[i] == tmo[i]) begin
        m_err[i]  = 1;
        m_halt[i] = 1;
        m_wait[i] = 0;
      end else m_wait[i]++;
    end else begin
      bw = m_bub[i];
      m_bub[i] = 0;
      if (halt) m_halt[i] = 1;
      else if (mem_req && !mem_done) m_wait[i] = 1;
      else if (!branch_taken && load_use && !bw) m_bub[i] = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    upd(0);
    upd(1);
    @(negedge clk);
  endtask

  task automatic drv(input bit h, input bit r, input bit mr,
                     input bit md, input bit bt, input bit lu);
    halt = h;
    resume = r;
    mem_req = mr;
    mem_done = md;
    branch_taken = bt;
    load_use = lu;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    drv(1, 0, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (halted16 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_halted got=%b exp=1", halted16);
    end
    rst = 1'b0;
    drv(1, 1, 1, 0, 1, 1);
    n_checks++;
    if (o16 !== NONE || halted16 !== 1'b0 || o4 !== NONE) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b/%b h=%b exp=0", o16, o4, halted16);
    end
    tick();
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) tick();
    n_checks++;
    if (o16 !== ALL || o4 !== ALL) begin
      n_fail++;
      $display("FAIL reset_idle_en got=%b/%b exp=%b", o16, o4, ALL);
    end
    n_checks++;
    if (cnt16 !== 16'd0 || halted16 !== 1'b0 || err16 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_state cnt=%0d h=%b e=%b exp 0", cnt16, halted16, err16);
    end
  endtask

  task automatic test_memwait();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drv(0, 0, 1, 0, 0, 0);
      n_checks++;
      if (o16 !== NONE) begin
        n_fail++;
        $display("FAIL memwait_stall c%0d got=%b exp=%b", k, o16, NONE);
      end
      tick();
    end
    drv(0, 0, 1, 1, 0, 0);
    n_checks++;
    if (o16 !== ALL) begin
      n_fail++;
      $display("FAIL memwait_done got=%b exp=%b", o16, ALL);
    end
    tick();
    drv(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (cnt16 !== 16'd3 || o16 !== ALL) begin
      n_fail++;
      $display("FAIL memwait_after cnt=%0d o=%b exp 3/%b", cnt16, o16, ALL);
    end
    drv(0, 0, 1, 1, 0, 0);
    n_checks++;
    if (o16 !== ALL) begin
      n_fail++;
      $display("FAIL mem_single_cycle got=%b exp=%b", o16, ALL);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drv(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (o16 !== LU) begin
      n_fail++;
      $display("FAIL load_use_c1 got=%b exp=%b", o16, LU);
    end
    tick();
    n_checks++;
    if (o16 !== ALL) begin
      n_fail++;
      $display("FAIL load_use_bubble got=%b exp=%b", o16, ALL);
    end
    tick();
    drv(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (cnt16 !== 16'd1) begin
      n_fail++;
      $display("FAIL load_use_cnt got=%0d exp=1", cnt16);
    end
  endtask

  task automatic test_branch();
    logic [15:0] c0;
    c0 = cnt16;
    drv(0, 0, 0, 0, 1, 1);
    n_checks++;
    if (o16 !== BR) begin
      n_fail++;
      $display("FAIL branch_lu got=%b exp=%b", o16, BR);
    end
    tick();
    drv(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (o16 !== LU) begin
      n_fail++;
      $display("FAIL branch_no_bubble got=%b exp=%b", o16, LU);
    end
    n_checks++;
    if (cnt16 !== c0) begin
      n_fail++;
      $display("FAIL branch_cnt got=%0d exp=%0d", cnt16, c0);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    drv(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) tick();
    n_checks++;
    if (halted4 !== 1'b0 || err4 !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early h=%b e=%b exp 0/0", halted4, err4);
    end
    tick();
    n_checks++;
    if (halted4 !== 1'b1 || err4 !== 1'b1 || err16 !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_hit h=%b e=%b e16=%b exp 1/1/0", halted4, err4, err16);
    end
    drv(0, 1, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (halted4 !== 1'b0 || err4 !== 1'b1 || o4 !== ALL) begin
      n_fail++;
      $display("FAIL timeout_resume h=%b e=%b o=%b exp 0/1/%b", halted4, err4, o4, ALL);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (err4 !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_rst_clr got=%b exp=0", err4);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    drv(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) tick();
    n_checks++;
    if (cnt4 !== 4'd15 || cnt16 !== 16'd20) begin
      n_fail++;
      $display("FAIL saturate got=%0d/%0d exp=15/20", cnt4, cnt16);
    end
    drv(1, 1, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (halted16 !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_resume_both got=%b exp=1", halted16);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      drv($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 25);
      n_checks++;
      if (o16 !== exp_out(0) || o4 !== exp_out(1)) begin
        n_fail++;
        $display("FAIL rand_en n=%0d got=%b/%b exp=%b/%b", n, o16, o4, exp_out(0), exp_out(1));
      end
      n_checks++;
      if (halted16 !== (rst && m_halt[0]) || halted4 !== (rst && m_halt[1])) begin
        n_fail++;
        $display("FAIL rand_halted n=%0d got=%b/%b exp=%b/%b", n, halted16, halted4, m_halt[0], m_halt[1]);
      end
      n_checks++;
      if (err16 !== m_err[0] || err4 !== m_err[1]) begin
        n_fail++;
        $display("FAIL rand_err n=%0d got=%b/%b exp=%b/%b", n, err16, err4, m_err[0], m_err[1]);
      end
      n_checks++;
      if (cnt16 !== 16'(m_cnt[0]) || cnt4 !== 4'(m_cnt[1])) begin
        n_fail++;
        $display("FAIL rand_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n, cnt16, cnt4, m_cnt[0], m_cnt[1]);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    halt = 1'b0;
    resume = 1'b0;
    mem_req = 1'b0;
    mem_done = 1'b0;
    branch_taken = 1'b0;
    load_use = 1'b0;
    @(negedge clk);
    test_reset();
    test_memwait();
    test_load_use();
    test_branch();
    test_timeout();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
